adc_ltc2308_ctrl: RTL and testbench
===================================

ADC_LTC2308_CTRL -- requirements
Module: adc_ltc2308_ctrl

Interface
REQ-001 Parameter CONV_CYCLES, default 64: clk cycles from CONVST rise to first SCK edge (1.6 us tCONV at 40 MHz).
REQ-002 Parameter CONVST_HIGH, default 2: clk cycles CONVST is held high.
REQ-003 Parameter SCK_DIV, default 4: clk cycles per SCK period, even, minimum 2.
REQ-004 clk  in  1  40 MHz conversion clock from the ADC PLL outclk_0; sole clock.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 pll_locked  in  1  ADC PLL lock indicator; frames run only while high.
REQ-007 start  in  1  single-cycle request for one conversion frame.
REQ-008 channel  in  3  channel to program for the NEXT conversion; sampled with start.
REQ-009 uni  in  1  1 = unipolar, 0 = bipolar for the next conversion; sampled with start.
REQ-010 busy  out  1  high from accepted start until the frame ends or aborts.
REQ-011 data_valid  out  1  one-cycle pulse qualifying data and data_channel.
REQ-012 data  out  12  conversion result, MSB first from SDO.
REQ-013 data_channel  out  3  channel that produced data.
REQ-014 adc_convst, adc_sck, adc_sdi  out  1 each  LTC2308 pins.
REQ-015 adc_sdo  in  1  LTC2308 serial data out.

Function
REQ-016 States: IDLE, CONV, SHIFT, DONE.
REQ-017 IDLE -> CONV when start=1 and pll_locked=1; channel/uni captured into config register that cycle; otherwise start ignored.
REQ-018 start while busy=1 is ignored; no queuing.
REQ-019 CONV: adc_convst=1 for the first CONVST_HIGH cycles, then 0; state lasts exactly CONV_CYCLES cycles, then SHIFT.
REQ-020 SHIFT: 12 SCK periods; adc_sck low for SCK_DIV/2 cycles then high for SCK_DIV/2; idle level low.
REQ-021 adc_sdi changes only while adc_sck low; bits in order S/D=1 (single-ended), O/S=channel[0], S1=channel[2], S0=channel[1], UNI=uni, SLP=0, then six 0s.
REQ-022 adc_sdo sampled in the clk cycle adc_sck rises; shifted MSB first into a 12-bit register.
REQ-023 SHIFT lasts exactly 12*SCK_DIV cycles, then DONE.
REQ-024 DONE: one cycle; data_valid=1; data=shift register; data_channel=channel programmed by the previous completed frame; then IDLE, busy=0.
REQ-025 Config register holding the previous frame's channel is updated to the current frame's channel in DONE, after data_channel is driven.
REQ-026 First frame after reset reports data_channel=0 (LTC2308 power-up default).
REQ-027 Frame latency start-to-data_valid = 1 + CONV_CYCLES + 12*SCK_DIV cycles (113 at defaults); start accepted again the cycle after DONE.
REQ-028 pll_locked low in CONV or SHIFT: abort to IDLE next cycle; no data_valid; convst, sck, sdi forced 0; previous-channel register unchanged.
REQ-029 data and data_channel hold their value between data_valid pulses.

Reset
REQ-030 reset_n low: state IDLE; busy, data_valid, adc_convst, adc_sck, adc_sdi = 0; data=0; data_channel=0; previous-channel register=0.
REQ-031 Reset mid-frame terminates immediately with no partial data_valid.
REQ-032 Outputs registered; no glitches on adc_* pins.

Structure
REQ-033 Shared package holds the state enum, 12-bit result width, 6-bit config width and config bit positions.
REQ-034 One sub-module, adc_sck_gen: SCK_DIV phase counter producing sck level, rise-strobe and fall-strobe.
REQ-035 Top module holds the FSM, config/shift registers and output registers only.

Verification
REQ-036 Reset, locked=1, start ch=5 uni=1, SDO model returns 0xA5C -> convst high cycles 1-2, 12 SCK pulses, data_valid at cycle 113, data=0xA5C, data_channel=0, SDI bits 1,1,1,0,1,0.
REQ-037 Second start ch=2, SDO 0x123 -> data=0x123, data_channel=5.
REQ-038 start pulses at cycles 10 and 50 of a frame -> ignored; exactly one data_valid.
REQ-039 pll_locked dropped at SCK pulse 6 -> busy=0 next cycle, no data_valid, pins 0; next frame reports previous completed channel.
REQ-040 start with pll_locked=0 -> busy stays 0, no pin activity.
REQ-041 reset_n asserted mid-SHIFT -> all outputs 0 asynchronously; next frame reports data_channel=0.

Source files
------------

// File: rtl/adc_ltc2308_ctrl_pkg.sv
// Shared definitions for the LTC2308 conversion controller.
// Holds the frame state enum, the result and config word widths, the bit
// positions of the six-bit LTC2308 configuration word, and a helper that
// assembles that word from a channel number and the unipolar flag.
package adc_ltc2308_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int RESULT_W = 12;
  localparam int CFG_W    = 6;

  // Positions inside the config word; bit CFG_W-1 goes out on SDI first.
  localparam int CFG_SD  = 5;
  localparam int CFG_OS  = 4;
  localparam int CFG_S1  = 3;
  localparam int CFG_S0  = 2;
  localparam int CFG_UNI = 1;
  localparam int CFG_SLP = 0;

  // The LTC2308 channel mux is addressed as O/S = ch[0], S1 = ch[2],
  // S0 = ch[1]; the controller always requests single-ended, awake mode.
  function automatic logic [CFG_W-1:0] build_cfg(input logic [2:0] ch,
                                                 input logic       uni);
    logic [CFG_W-1:0] w;
    w          = '0;
    w[CFG_SD]  = 1'b1;
    w[CFG_OS]  = ch[0];
    w[CFG_S1]  = ch[2];
    w[CFG_S0]  = ch[1];
    w[CFG_UNI] = uni;
    w[CFG_SLP] = 1'b0;
    return w;
  endfunction

endpackage

// File: rtl/adc_ltc2308_ctrl_sck_gen.sv
// SCK phase generator for the LTC2308 serial port.
// Ports:
//   clk, reset_n : conversion clock, asynchronous active-low reset
//   en           : high when the controller will be shifting next cycle
//   sck          : registered SCK level (low half first, then high half)
//   rise         : high in the clk cycle in which sck is first high
//   fall         : high in the first (low) clk cycle of every SCK period
module adc_sck_gen
  import adc_ltc2308_ctrl_pkg::*;
#(
  parameter int SCK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam int PW = (SCK_DIV > 2) ? $clog2(SCK_DIV) : 1;
  localparam logic [PW-1:0] HALF = PW'(SCK_DIV / 2);
  localparam logic [PW-1:0] LAST = PW'(SCK_DIV - 1);

  logic [PW-1:0] phase, phase_next;
  logic          active;

  // Phase restarts at zero on the first shifting cycle and is held at zero
  // whenever shifting stops, so every frame begins with a full low half.
  always_comb begin
    phase_next = '0;
    if (en && active) begin
      phase_next = (phase == LAST) ? '0 : phase + PW'(1);
    end
  end

  // SCK is registered from the next phase so the pin never glitches and
  // drops to its idle low level on the same edge that shifting ends.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase  <= '0;
      active <= 1'b0;
      sck    <= 1'b0;
    end else begin
      phase  <= phase_next;
      active <= en;
      sck    <= en && (phase_next >= HALF);
    end
  end

  assign rise = active && (phase == HALF);
  assign fall = active && (phase == '0);

endmodule

// File: rtl/adc_ltc2308_ctrl.sv
// LTC2308 conversion frame controller.
// One accepted start runs a frame: CONVST pulse and conversion wait, twelve
// SCK periods that send the next channel config on SDI while reading the
// previous conversion from SDO, then a one-cycle data_valid.
// Ports:
//   clk, reset_n          : 40 MHz conversion clock, async active-low reset
//   pll_locked            : frames run only while high
//   start, channel, uni   : frame request and config for the next conversion
//   busy, data_valid      : frame in progress, result qualifier
//   data, data_channel    : 12-bit result and the channel that produced it
//   adc_convst/sck/sdi/sdo: LTC2308 pins
module adc_ltc2308_ctrl
  import adc_ltc2308_ctrl_pkg::*;
#(
  parameter int CONV_CYCLES = 64,
  parameter int CONVST_HIGH = 2,
  parameter int SCK_DIV     = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                pll_locked,
  input  logic                start,
  input  logic [2:0]          channel,
  input  logic                uni,
  output logic                busy,
  output logic                data_valid,
  output logic [RESULT_W-1:0] data,
  output logic [2:0]          data_channel,
  output logic                adc_convst,
  output logic                adc_sck,
  output logic                adc_sdi,
  input  logic                adc_sdo
);

  localparam logic [15:0] CONV_LAST  = 16'(CONV_CYCLES - 1);
  localparam logic [15:0] SHIFT_LAST = 16'(RESULT_W * SCK_DIV - 1);
  localparam logic [15:0] CONVST_LIM = 16'(CONVST_HIGH);

  state_t              state, state_next;
  logic [15:0]         cnt, cnt_next;
  logic [2:0]          cur_ch, prev_ch;
  logic [CFG_W-1:0]    cfg_sr;
  logic [RESULT_W-1:0] shift_sr;
  logic                sck_en, sck_rise, sck_fall;

  // Next-state logic; losing PLL lock mid-frame abandons the frame.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start && pll_locked) state_next = CONV;
      CONV: begin
        if (!pll_locked)            state_next = IDLE;
        else if (cnt == CONV_LAST)  state_next = SHIFT;
      end
      SHIFT: begin
        if (!pll_locked)            state_next = IDLE;
        else if (cnt == SHIFT_LAST) state_next = DONE;
      end
      DONE:                         state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
    cnt_next = '0;
    if (state_next == state && state != IDLE) begin
      cnt_next = cnt + 16'd1;
    end
  end

  assign sck_en = (state_next == SHIFT);

  adc_sck_gen #(
    .SCK_DIV (SCK_DIV)
  ) u_sck_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (sck_en),
    .sck     (adc_sck),
    .rise    (sck_rise),
    .fall    (sck_fall)
  );

  // All outputs are registered from the next state so they line up with the
  // state they describe. SDI is updated one cycle into each low SCK half so
  // it never moves while SCK is high. data_channel takes the old prev_ch on
  // the same edge that prev_ch takes the channel just converted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      cur_ch       <= '0;
      prev_ch      <= '0;
      cfg_sr       <= '0;
      shift_sr     <= '0;
      busy         <= 1'b0;
      data_valid   <= 1'b0;
      data         <= '0;
      data_channel <= '0;
      adc_convst   <= 1'b0;
      adc_sdi      <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      busy       <= (state_next != IDLE);
      data_valid <= (state_next == DONE);
      adc_convst <= (state_next == CONV) && (cnt_next < CONVST_LIM);

      if (state == IDLE && state_next == CONV) begin
        cur_ch   <= channel;
        cfg_sr   <= build_cfg(channel, uni);
        shift_sr <= '0;
      end

      if (state == SHIFT && sck_rise) begin
        shift_sr <= {shift_sr[RESULT_W-2:0], adc_sdo};
      end

      if (state_next != SHIFT) begin
        adc_sdi <= 1'b0;
      end else if (state == SHIFT && sck_fall) begin
        adc_sdi <= cfg_sr[CFG_W-1];
        cfg_sr  <= {cfg_sr[CFG_W-2:0], 1'b0};
      end

      if (state_next == DONE) begin
        data         <= shift_sr;
        data_channel <= prev_ch;
        prev_ch      <= cur_ch;
      end
    end
  end

endmodule

// File: tb/tb_adc_ltc2308_ctrl.sv
// Self-checking bench for adc_ltc2308_ctrl: directed frames plus random
// channel/uni/result frames against a frame-level reference model.
`timescale 1ns/1ps
module tb_adc_ltc2308_ctrl;

  localparam int CONV_CYCLES = 64;
  localparam int CONVST_HIGH = 2;
  localparam int SCK_DIV     = 4;
  localparam int LAT         = 1 + CONV_CYCLES + 12 * SCK_DIV;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pll_locked;
  logic        start;
  logic [2:0]  channel;
  logic        uni;
  logic        busy;
  logic        data_valid;
  logic [11:0] data;
  logic [2:0]  data_channel;
  logic        adc_convst;
  logic        adc_sck;
  logic        adc_sdi;
  logic        adc_sdo;

  int checks = 0;
  int errors = 0;

  // Reference model state: channel of the last completed frame and the
  // last reported result, which must hold between data_valid pulses.
  logic [2:0]  model_prev;
  logic [11:0] last_word;
  logic [2:0]  last_ch;

  adc_ltc2308_ctrl #(
    .CONV_CYCLES (CONV_CYCLES),
    .CONVST_HIGH (CONVST_HIGH),
    .SCK_DIV     (SCK_DIV)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pll_locked   (pll_locked),
    .start        (start),
    .channel      (channel),
    .uni          (uni),
    .busy         (busy),
    .data_valid   (data_valid),
    .data         (data),
    .data_channel (data_channel),
    .adc_convst   (adc_convst),
    .adc_sck      (adc_sck),
    .adc_sdi      (adc_sdi),
    .adc_sdo      (adc_sdo)
  );

  always #12.5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [2:0] ch, input logic u);
    @(negedge clk);
    start   = s;
    channel = ch;
    uni     = u;
  endtask

  // SDI sequence the LTC2308 expects: S/D, O/S, S1, S0, UNI, SLP, six zeros.
  function automatic logic [11:0] sdiWord(input logic [2:0] ch, input logic u);
    return {1'b1, ch[0], ch[2], ch[1], u, 1'b0, 6'b0};
  endfunction

  // Runs one requested frame cycle by cycle, acting as the ADC on SDO and
  // observing every pin at the falling clk edge. abort_pulse / reset_pulse
  // (non-zero) drop pll_locked / assert reset_n at that SCK pulse.
  task automatic runFrame(input logic [2:0] ch, input logic u, input logic [11:0] word,
                          input int abort_pulse, input int reset_pulse, input bit extra_starts);
    int rises = 0, falls = 0, dv_count = 0, dv_cycle = -1, busy_cycles = 0;
    int convst_cycles = 0, convst_first = -1, sdi_viol = 0, abort_cycle = -1;
    logic [11:0] sdi_bits = '0, got_data = '0;
    logic [2:0]  got_ch = '0;
    logic sck_prev = 1'b0, sdi_prev = 1'b0;
    adc_sdo = word[11];
    applyStimulus(1'b1, ch, u);
    for (int n = 1; n <= LAT + 15; n++) begin
      @(negedge clk);
      if (extra_starts && (n == 10 || n == 50)) begin
        start = 1'b1; channel = ~ch; uni = ~u;
      end else begin
        start = 1'b0;
      end
      if (adc_convst) begin
        convst_cycles++;
        if (convst_first < 0) convst_first = n;
      end
      if (busy) busy_cycles++;
      if (data_valid) begin
        dv_count++; dv_cycle = n; got_data = data; got_ch = data_channel;
      end
      if (adc_sck && sck_prev && adc_sdi !== sdi_prev) sdi_viol++;
      if (!adc_sck && sck_prev) begin
        falls++;
        adc_sdo = (falls < 12) ? word[11 - falls] : 1'b0;
      end
      if (abort_cycle > 0 && n == abort_cycle + 1) begin
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_pins", 32'({adc_convst, adc_sck, adc_sdi}), 32'd0);
      end
      if (adc_sck && !sck_prev) begin
        rises++;
        sdi_bits = {sdi_bits[10:0], adc_sdi};
        if (abort_pulse > 0 && rises == abort_pulse) begin
          pll_locked  = 1'b0;
          abort_cycle = n;
        end
        if (reset_pulse > 0 && rises == reset_pulse) begin
          reset_n = 1'b0;
          #1;
          checkOutput("reset_mid_outputs",
                      32'({busy, data_valid, adc_convst, adc_sck, adc_sdi, data, data_channel}),
                      32'd0);
          #2 reset_n = 1'b1;
          model_prev = '0; last_word = '0; last_ch = '0;
          break;
        end
      end
      sck_prev = adc_sck;
      sdi_prev = adc_sdi;
    end
    if (reset_pulse > 0) return;
    if (abort_pulse > 0) begin
      checkOutput("abort_no_valid", 32'(dv_count), 32'd0);
      checkOutput("abort_pulses", 32'(rises), 32'(abort_pulse));
      checkOutput("abort_hold_data", 32'(data), 32'(last_word));
      checkOutput("abort_hold_ch", 32'(data_channel), 32'(last_ch));
      pll_locked = 1'b1;
      return;
    end
    checkOutput("valid_count", 32'(dv_count), 32'd1);
    checkOutput("valid_cycle", 32'(dv_cycle), 32'(LAT));
    checkOutput("data", 32'(got_data), 32'(word));
    checkOutput("data_channel", 32'(got_ch), 32'(model_prev));
    checkOutput("convst_cycles", 32'(convst_cycles), 32'(CONVST_HIGH));
    checkOutput("convst_first", 32'(convst_first), 32'd1);
    checkOutput("sck_pulses", 32'(rises), 32'd12);
    checkOutput("sdi_bits", 32'(sdi_bits), 32'(sdiWord(ch, u)));
    checkOutput("sdi_stable", 32'(sdi_viol), 32'd0);
    checkOutput("busy_cycles", 32'(busy_cycles), 32'(LAT));
    checkOutput("hold_data", 32'(data), 32'(word));
    checkOutput("hold_ch", 32'(data_channel), 32'(model_prev));
    last_word  = word;
    last_ch    = model_prev;
    model_prev = ch;
  endtask

  initial begin
    logic [2:0]  rch;
    logic        ru;
    logic [11:0] rw;
    int          activity;

    reset_n = 1'b0; pll_locked = 1'b1; start = 1'b0;
    channel = '0; uni = 1'b0; adc_sdo = 1'b0;
    model_prev = '0; last_word = '0; last_ch = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
                32'({busy, data_valid, adc_convst, adc_sck, adc_sdi, data, data_channel}), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] frame ch=5 uni=1 result 0xA5C");
    runFrame(3'd5, 1'b1, 12'hA5C, 0, 0, 1'b0);

    $display("[TB] frame ch=2 result 0x123 with ignored starts");
    runFrame(3'd2, 1'b0, 12'h123, 0, 0, 1'b1);

    $display("[TB] PLL lock lost at SCK pulse 6");
    runFrame(3'($urandom_range(0, 7)), 1'($urandom), 12'($urandom), 6, 0, 1'b0);
    runFrame(3'd7, 1'b1, 12'($urandom), 0, 0, 1'b0);

    $display("[TB] start while PLL unlocked");
    pll_locked = 1'b0;
    applyStimulus(1'b1, 3'd3, 1'b1);
    activity = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy || adc_convst || adc_sck || adc_sdi || data_valid) activity++;
    end
    checkOutput("unlocked_activity", 32'(activity), 32'd0);
    pll_locked = 1'b1;
    @(negedge clk);

    $display("[TB] reset mid-shift");
    runFrame(3'd6, 1'b0, 12'hFFF, 0, 4, 1'b0);
    repeat (2) @(negedge clk);
    runFrame(3'd1, 1'b0, 12'h5A5, 0, 0, 1'b0);

    $display("[TB] random frames");
    for (int i = 0; i < 4; i++) begin
      rch = 3'($urandom_range(0, 7));
      ru  = 1'($urandom);
      rw  = 12'($urandom);
      runFrame(rch, ru, rw, 0, 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
